// File: rtl/mips_bus_arbiter_pkg.sv
// Shared types and constants for the I/D bus arbiter.
package mips_bus_arbiter_pkg;

  typedef enum logic {
    PortI = 1'b0,
    PortD = 1'b1
  } port_t;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t StIdle = 2'd0;
  localparam arb_state_t StBusy = 2'd1;
  localparam arb_state_t StTurn = 2'd2;

  localparam logic [31:0] DEFAULT_ABORT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/mips_bus_arbiter_if.sv
// Avalon-style memory bus: master drives command, slave returns data and stall.
interface mips_bus_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic                  read;
  logic                  write;
  logic [ADDR_W-1:0]     address;
  logic [DATA_W/8-1:0]   byteenable;
  logic [DATA_W-1:0]     writedata;
  logic [DATA_W-1:0]     readdata;
  logic                  waitrequest;

  modport master (
    output read, write, address, byteenable, writedata,
    input  readdata, waitrequest
  );

  modport slave (
    input  read, write, address, byteenable, writedata,
    output readdata, waitrequest
  );
endinterface

// File: rtl/mips_bus_arbiter_rr2.sv
// Two-requester picker: alternates on contention or gives the data port fixed priority.
module mips_bus_arbiter_rr2
  import mips_bus_arbiter_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic  req_ifetch_i,
  input  logic  req_data_i,
  input  port_t last_grant_i,
  output logic  gnt_valid_o,
  output port_t gnt_o
);

  always_comb begin
    gnt_valid_o = req_ifetch_i | req_data_i;
    gnt_o       = PortI;
    if (req_ifetch_i && req_data_i) begin
      gnt_o = (ROUND_ROBIN && (last_grant_i == PortD)) ? PortI : PortD;
    end else if (req_data_i) begin
      gnt_o = PortD;
    end
  end

endmodule

// File: rtl/mips_bus_arbiter.sv
// Shares one memory bus between the CPU fetch and data ports; one registered
// transaction owns the slave at a time, with a watchdog that aborts hung slaves.
module mips_bus_arbiter
  import mips_bus_arbiter_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter bit                ROUND_ROBIN = 1'b1,
  parameter int unsigned       TIMEOUT     = 64,
  parameter logic [DATA_W-1:0] ABORT_DATA  = DEFAULT_ABORT_DATA
) (
  input  logic               clk,
  input  logic               reset,
  mips_bus_arbiter_if.slave  i_bus,
  mips_bus_arbiter_if.slave  d_bus,
  mips_bus_arbiter_if.master s_bus,
  output logic               timeout_err,
  output logic               protocol_err
);

  localparam int unsigned    BE_W    = DATA_W / 8;
  localparam int unsigned    WD_W    = $clog2(TIMEOUT) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  arb_state_t        state_q, state_d;
  port_t             owner_q, owner_d;
  port_t             last_grant_q, last_grant_d;
  logic              s_read_q, s_read_d;
  logic              s_write_q, s_write_d;
  logic [ADDR_W-1:0] s_addr_q, s_addr_d;
  logic [BE_W-1:0]   s_be_q, s_be_d;
  logic [DATA_W-1:0] s_wdata_q, s_wdata_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic              timeout_err_q, timeout_err_d;
  logic              protocol_err_q, protocol_err_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic              req_i, req_d;
  logic              gnt_valid;
  port_t             gnt;
  logic              busy, abort, done;
  logic              deliver_i, deliver_d;
  logic [DATA_W-1:0] ret_data;
  logic              win_rd, win_wr;
  logic [ADDR_W-1:0] win_addr;
  logic [BE_W-1:0]   win_be;
  logic [DATA_W-1:0] win_wdata;

  assign req_i = i_bus.read | i_bus.write;
  assign req_d = d_bus.read | d_bus.write;

  mips_bus_arbiter_rr2 #(
    .ROUND_ROBIN (ROUND_ROBIN)
  ) u_rr2 (
    .req_ifetch_i (req_i),
    .req_data_i   (req_d),
    .last_grant_i (last_grant_q),
    .gnt_valid_o  (gnt_valid),
    .gnt_o        (gnt)
  );

  assign busy     = (state_q == StBusy);
  assign abort    = busy && s_bus.waitrequest && (wdog_q == WD_LAST);
  assign done     = busy && (!s_bus.waitrequest || abort);
  assign ret_data = abort ? ABORT_DATA : s_bus.readdata;

  // A master that dropped its request mid-transaction never sees the result.
  assign deliver_i = done && (owner_q == PortI) && req_i;
  assign deliver_d = done && (owner_q == PortD) && req_d;

  assign i_bus.waitrequest = ~deliver_i;
  assign d_bus.waitrequest = ~deliver_d;
  assign i_bus.readdata    = deliver_i ? ret_data : i_rdata_q;
  assign d_bus.readdata    = deliver_d ? ret_data : d_rdata_q;

  assign s_bus.read       = s_read_q;
  assign s_bus.write      = s_write_q;
  assign s_bus.address    = s_addr_q;
  assign s_bus.byteenable = s_be_q;
  assign s_bus.writedata  = s_wdata_q;

  assign timeout_err  = timeout_err_q;
  assign protocol_err = protocol_err_q;

  always_comb begin
    win_rd    = (gnt == PortD) ? d_bus.read       : i_bus.read;
    win_wr    = (gnt == PortD) ? d_bus.write      : i_bus.write;
    win_addr  = (gnt == PortD) ? d_bus.address    : i_bus.address;
    win_be    = (gnt == PortD) ? d_bus.byteenable : i_bus.byteenable;
    win_wdata = (gnt == PortD) ? d_bus.writedata  : i_bus.writedata;
  end

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_grant_d   = last_grant_q;
    s_read_d       = s_read_q;
    s_write_d      = s_write_q;
    s_addr_d       = s_addr_q;
    s_be_d         = s_be_q;
    s_wdata_d      = s_wdata_q;
    wdog_d         = wdog_q;
    timeout_err_d  = timeout_err_q;
    protocol_err_d = protocol_err_q;
    i_rdata_d      = deliver_i ? ret_data : i_rdata_q;
    d_rdata_d      = deliver_d ? ret_data : d_rdata_q;

    case (state_q)
      StIdle: begin
        if (gnt_valid) begin
          state_d      = StBusy;
          owner_d      = gnt;
          last_grant_d = gnt;
          // Read and write together is illegal; the write wins.
          s_write_d    = win_wr;
          s_read_d     = win_rd & ~win_wr;
          s_addr_d     = win_addr;
          s_be_d       = win_be;
          s_wdata_d    = win_wdata;
          wdog_d       = '0;
          if (win_rd && win_wr) protocol_err_d = 1'b1;
        end
      end
      StBusy: begin
        if (done) begin
          state_d   = StTurn;
          s_read_d  = 1'b0;
          s_write_d = 1'b0;
          if (abort) timeout_err_d = 1'b1;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      StTurn:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= StIdle;
      owner_q        <= PortI;
      last_grant_q   <= PortI;
      s_read_q       <= 1'b0;
      s_write_q      <= 1'b0;
      s_addr_q       <= '0;
      s_be_q         <= '0;
      s_wdata_q      <= '0;
      wdog_q         <= '0;
      timeout_err_q  <= 1'b0;
      protocol_err_q <= 1'b0;
      i_rdata_q      <= '0;
      d_rdata_q      <= '0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      last_grant_q   <= last_grant_d;
      s_read_q       <= s_read_d;
      s_write_q      <= s_write_d;
      s_addr_q       <= s_addr_d;
      s_be_q         <= s_be_d;
      s_wdata_q      <= s_wdata_d;
      wdog_q         <= wdog_d;
      timeout_err_q  <= timeout_err_d;
      protocol_err_q <= protocol_err_d;
      i_rdata_q      <= i_rdata_d;
      d_rdata_q      <= d_rdata_d;
    end
  end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Scoreboard bench: round-robin DUT on a wait-state RAM, fixed-priority DUT on a zero-wait slave.
module tb_mips_bus_arbiter;
  import mips_bus_arbiter_pkg::*;

  typedef struct {
    bit          port;  // 1 = D
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mips_bus_arbiter_if i_bus ();
  mips_bus_arbiter_if d_bus ();
  mips_bus_arbiter_if s_bus ();
  mips_bus_arbiter_if i2_bus ();
  mips_bus_arbiter_if d2_bus ();
  mips_bus_arbiter_if s2_bus ();
  logic timeout_err, protocol_err, timeout_err2, protocol_err2;

  mips_bus_arbiter #(.ROUND_ROBIN(1'b1), .TIMEOUT(64)) dut (
    .clk(clk), .reset(rst_n), .i_bus(i_bus), .d_bus(d_bus), .s_bus(s_bus),
    .timeout_err(timeout_err), .protocol_err(protocol_err)
  );

  mips_bus_arbiter #(.ROUND_ROBIN(1'b0), .TIMEOUT(64)) dut2 (
    .clk(clk), .reset(rst_n), .i_bus(i2_bus), .d_bus(d2_bus), .s_bus(s2_bus),
    .timeout_err(timeout_err2), .protocol_err(protocol_err2)
  );

  int n_pass = 0;
  int n_total = 0;
  exp_t sb[$];
  exp_t sb2[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // RAM slave with programmable wait states (or stuck stall).
  logic [31:0] mem [0:255];
  int unsigned wait_cfg = 0;
  int unsigned wcnt = 0;
  bit stuck = 1'b0;
  bit preload = 1'b1;

  assign s_bus.waitrequest = stuck || ((s_bus.read || s_bus.write) && (wcnt < wait_cfg));
  assign s_bus.readdata    = mem[s_bus.address[9:2]];
  assign s2_bus.waitrequest = 1'b0;
  assign s2_bus.readdata    = s2_bus.address ^ 32'hA500_0000;

  always @(posedge clk) begin
    if (preload) begin
      for (int k = 0; k < 256; k++) mem[k] <= 32'h0;
      mem[0]  <= 32'h2402_000A;
      mem[1]  <= 32'h3333_4444;
      mem[16] <= 32'h1111_2222;
    end else if (s_bus.write && !s_bus.waitrequest) begin
      for (int b = 0; b < 4; b++)
        if (s_bus.byteenable[b]) mem[s_bus.address[9:2]][8*b +: 8] <= s_bus.writedata[8*b +: 8];
    end
    if ((s_bus.read || s_bus.write) && s_bus.waitrequest) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  task automatic sb_check(input bit port, input logic [31:0] rdata);
    exp_t e;
    chk("pending_expect", 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("order_port", 32'(port), 32'(e.port));
      chk("slave_addr", s_bus.address, e.addr);
      if (e.wr) begin
        chk("wr_strobes", {30'b0, s_bus.read, s_bus.write}, 32'd1);
        chk("wr_data", s_bus.writedata, e.data);
        chk("wr_be", 32'(s_bus.byteenable), 32'(e.be));
      end else begin
        chk("rd_data", rdata, e.data);
      end
    end
  endtask

  task automatic sb2_check(input bit port, input logic [31:0] rdata);
    exp_t e;
    chk("pending_expect2", 32'(sb2.size() > 0), 32'd1);
    if (sb2.size() > 0) begin
      e = sb2.pop_front();
      chk("order_port2", 32'(port), 32'(e.port));
      chk("rd_data2", rdata, e.data);
    end
  endtask

  always @(negedge clk) begin
    if (!i_bus.waitrequest)  sb_check(1'b0, i_bus.readdata);
    if (!d_bus.waitrequest)  sb_check(1'b1, d_bus.readdata);
    if (!i2_bus.waitrequest) sb2_check(1'b0, i2_bus.readdata);
    if (!d2_bus.waitrequest) sb2_check(1'b1, d2_bus.readdata);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one transaction on DUT1 port and hold it until accepted (bounded).
  task automatic txn(input bit port, input bit rd, input bit wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be, input int budget);
    bit ok;
    ok = 1'b0;
    if (port) begin
      d_bus.read = rd; d_bus.write = wr; d_bus.address = addr;
      d_bus.writedata = wdata; d_bus.byteenable = be;
    end else begin
      i_bus.read = rd; i_bus.write = wr; i_bus.address = addr;
      i_bus.writedata = wdata; i_bus.byteenable = be;
    end
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      ok = port ? !d_bus.waitrequest : !i_bus.waitrequest;
    end
    chk("txn_completes", 32'(ok), 32'd1);
    tick();
    if (port) begin d_bus.read = 1'b0; d_bus.write = 1'b0; end
    else begin i_bus.read = 1'b0; i_bus.write = 1'b0; end
  endtask

  // Count slave strobe cycles and any drift of the registered command.
  task automatic watch_cmd(input int n, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, output int cnt, output int bad);
    cnt = 0;
    bad = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (s_bus.read || s_bus.write) begin
        cnt++;
        if (s_bus.address != addr || s_bus.byteenable != be) bad++;
        if (s_bus.write && s_bus.writedata != wdata) bad++;
      end
    end
  endtask

  task automatic wait2(input bit port);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      ok = port ? !d2_bus.waitrequest : !i2_bus.waitrequest;
    end
    chk("txn2_completes", 32'(ok), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    int cnt, bad;
    i_bus.read = 0; i_bus.write = 0; i_bus.address = 0; i_bus.byteenable = 0; i_bus.writedata = 0;
    d_bus.read = 0; d_bus.write = 0; d_bus.address = 0; d_bus.byteenable = 0; d_bus.writedata = 0;
    i2_bus.read = 0; i2_bus.write = 0; i2_bus.address = 0; i2_bus.byteenable = 4'hF;
    i2_bus.writedata = 0;
    d2_bus.read = 0; d2_bus.write = 0; d2_bus.address = 0; d2_bus.byteenable = 4'hF;
    d2_bus.writedata = 0;
    #1 rst_n = 1'b0;
    tick();
    preload = 1'b0;
    @(negedge clk);
    chk("rst_s_read", 32'(s_bus.read), 32'd0);
    chk("rst_s_write", 32'(s_bus.write), 32'd0);
    chk("rst_s_address", s_bus.address, 32'd0);
    chk("rst_s_writedata", s_bus.writedata, 32'd0);
    chk("rst_i_wait", 32'(i_bus.waitrequest), 32'd1);
    chk("rst_d_wait", 32'(d_bus.waitrequest), 32'd1);
    chk("rst_i_rdata", i_bus.readdata, 32'd0);
    chk("rst_d_rdata", d_bus.readdata, 32'd0);
    chk("rst_errs", {30'b0, timeout_err, protocol_err}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single fetch read with two wait states.
    wait_cfg = 2;
    sb.push_back('{1'b0, 1'b0, 32'h0, 32'h2402_000A, 4'hF});
    txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF, 20);
    @(negedge clk);
    chk("t1_i_wait_turn", 32'(i_bus.waitrequest), 32'd1);
    chk("t1_d_wait_turn", 32'(d_bus.waitrequest), 32'd1);
    chk("t1_i_rdata_hold", i_bus.readdata, 32'h2402_000A);
    chk("t1_d_rdata_clean", d_bus.readdata, 32'h0);
    tick();

    // Contention with last grant I: D first, then I.
    wait_cfg = 0;
    sb.push_back('{1'b1, 1'b0, 32'h40, 32'h1111_2222, 4'hF});
    sb.push_back('{1'b0, 1'b0, 32'h4, 32'h3333_4444, 4'hF});
    fork
      txn(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF, 20);
      txn(1'b0, 1'b1, 1'b0, 32'h4, 32'h0, 4'hF, 20);
    join
    tick();

    // Masked write held stable across wait states, then read back.
    wait_cfg = 3;
    sb.push_back('{1'b1, 1'b1, 32'h100, 32'hCAFE_F00D, 4'b0011});
    fork
      txn(1'b1, 1'b0, 1'b1, 32'h100, 32'hCAFE_F00D, 4'b0011, 20);
      watch_cmd(8, 32'h100, 32'hCAFE_F00D, 4'b0011, cnt, bad);
    join
    chk("t3_strobe_cycles", 32'(cnt), 32'd4);
    chk("t3_cmd_stable", 32'(bad), 32'd0);
    tick();
    wait_cfg = 0;
    sb.push_back('{1'b1, 1'b0, 32'h100, 32'h0000_F00D, 4'hF});
    txn(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 20);
    tick();

    // Contention with last grant D: I first.
    sb.push_back('{1'b0, 1'b0, 32'h0, 32'h2402_000A, 4'hF});
    sb.push_back('{1'b1, 1'b0, 32'h100, 32'h0000_F00D, 4'hF});
    fork
      txn(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 20);
      txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF, 20);
    join
    tick();

    // Hung slave: abort on the 64th stalled BUSY cycle.
    chk("t5_timeout_err_before", 32'(timeout_err), 32'd0);
    stuck = 1'b1;
    sb.push_back('{1'b1, 1'b0, 32'h8, 32'hDEAD_BEEF, 4'hF});
    fork
      txn(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 4'hF, 100);
      watch_cmd(80, 32'h8, 32'h0, 4'hF, cnt, bad);
    join
    stuck = 1'b0;
    chk("t5_busy_cycles", 32'(cnt), 32'd64);
    chk("t5_timeout_err", 32'(timeout_err), 32'd1);
    chk("t5_i_rdata_hold", i_bus.readdata, 32'h2402_000A);
    tick();

    // Read and write together: issued as write, flagged.
    chk("t6_protocol_err_before", 32'(protocol_err), 32'd0);
    sb.push_back('{1'b1, 1'b1, 32'h200, 32'h1234_5678, 4'hF});
    txn(1'b1, 1'b1, 1'b1, 32'h200, 32'h1234_5678, 4'hF, 20);
    tick();
    chk("t6_protocol_err", 32'(protocol_err), 32'd1);
    chk("t6_timeout_sticky", 32'(timeout_err), 32'd1);
    sb.push_back('{1'b1, 1'b0, 32'h200, 32'h1234_5678, 4'hF});
    txn(1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 4'hF, 20);
    tick();

    // Reset in the middle of a stalled read.
    wait_cfg = 5;
    i_bus.read = 1'b1; i_bus.address = 32'h4; i_bus.byteenable = 4'hF;
    tick();
    #2;
    chk("t7_s_read_busy", 32'(s_bus.read), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t7_s_read_async", 32'(s_bus.read), 32'd0);
    chk("t7_i_wait", 32'(i_bus.waitrequest), 32'd1);
    chk("t7_d_wait", 32'(d_bus.waitrequest), 32'd1);
    i_bus.read = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t7_errs_cleared", {30'b0, timeout_err, protocol_err}, 32'd0);
    chk("t7_s_addr_cleared", s_bus.address, 32'd0);
    tick();
    wait_cfg = 0;
    sb.push_back('{1'b0, 1'b0, 32'h4, 32'h3333_4444, 4'hF});
    txn(1'b0, 1'b1, 1'b0, 32'h4, 32'h0, 4'hF, 20);
    tick();

    // Fixed priority: D keeps winning while it keeps requesting.
    sb2.push_back('{1'b1, 1'b0, 32'h20, 32'hA500_0020, 4'hF});
    sb2.push_back('{1'b1, 1'b0, 32'h24, 32'hA500_0024, 4'hF});
    sb2.push_back('{1'b1, 1'b0, 32'h28, 32'hA500_0028, 4'hF});
    sb2.push_back('{1'b0, 1'b0, 32'h10, 32'hA500_0010, 4'hF});
    i2_bus.read = 1'b1; i2_bus.address = 32'h10;
    d2_bus.read = 1'b1; d2_bus.address = 32'h20;
    for (int j = 0; j < 3; j++) begin
      wait2(1'b1);
      tick();
      if (j == 2) d2_bus.read = 1'b0;
      else d2_bus.address = d2_bus.address + 32'h4;
    end
    wait2(1'b0);
    tick();
    i2_bus.read = 1'b0;
    tick();
    tick();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("sb2_drained", 32'(sb2.size()), 32'd0);
    chk("dut2_errs", {30'b0, timeout_err2, protocol_err2}, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
